rhb_arbiter: RTL and testbench

Two-master bus arbiter for the RHB interconnect. It samples the active-low requests of master 0 and master 1 and grants the shared bus to one owner at a time, using round-robin priority when both request together. A per-grant watchdog forcibly revokes a grant that is held too long. It drives the per-master grant lines and the owner select that steers the RHB address, data and control muxes.

---
 rtl/rhb_arbiter.sv | 88 ++++++++
 tb/tb_rhb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rhb_arbiter.sv
// Two-master RHB bus arbiter: round-robin on simultaneous requests, per-grant watchdog.
// Grant 1 cycle after request, mandatory IDLE cycle on every handover, requests not queued while owned.
module rhb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req_,
  input  logic m1_req_,
  output logic m0_grnt,
  output logic m1_grnt,
  output logic owner,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam int unsigned        TLAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TLAST);

  state_t           state, state_nxt;
  logic             last;
  logic             timeout_nxt;
  logic             expired;
  logic [CNT_W-1:0] hold_cnt;

  assign expired = (TIMEOUT != 0) && (hold_cnt == TO_LAST);

  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!m0_req_ && !m1_req_)
          state_nxt = last ? OWN0 : OWN1;
        else if (!m0_req_)
          state_nxt = OWN0;
        else if (!m1_req_)
          state_nxt = OWN1;
      end
      // A release sampled together with the expiry compare wins over the watchdog.
      OWN0: begin
        if (m0_req_) begin
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      OWN1: begin
        if (m1_req_) begin
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= timeout_nxt;
      if (state == IDLE && state_nxt != IDLE) begin
        hold_cnt <= '0;
        owner    <= (state_nxt == OWN1);
        last     <= (state_nxt == OWN1);
      end else if (state != IDLE && hold_cnt != '1) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

  assign m0_grnt  = (state == OWN0);
  assign m1_grnt  = (state == OWN1);
  assign bus_busy = m0_grnt | m1_grnt;

endmodule

// File: tb/tb_rhb_arbiter.sv
// Bench for rhb_arbiter: three instances (TIMEOUT 255, 4, 0) share stimulus; vectors are hand-derived.
module tb_rhb_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic m0_req_, m1_req_;

  logic a_m0g, a_m1g, a_own, a_busy, a_terr;
  logic b_m0g, b_m1g, b_own, b_busy, b_terr;
  logic c_m0g, c_m1g, c_own, c_busy, c_terr;

  rhb_arbiter dut_a (
    .clk(clk), .reset(reset), .m0_req_(m0_req_), .m1_req_(m1_req_),
    .m0_grnt(a_m0g), .m1_grnt(a_m1g), .owner(a_own), .bus_busy(a_busy), .timeout_err(a_terr)
  );

  rhb_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .m0_req_(m0_req_), .m1_req_(m1_req_),
    .m0_grnt(b_m0g), .m1_grnt(b_m1g), .owner(b_own), .bus_busy(b_busy), .timeout_err(b_terr)
  );

  rhb_arbiter #(.TIMEOUT(0), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .m0_req_(m0_req_), .m1_req_(m1_req_),
    .m0_grnt(c_m0g), .m1_grnt(c_m1g), .owner(c_own), .bus_busy(c_busy), .timeout_err(c_terr)
  );

  always #5 clk = ~clk;

  // Output vector order: {m0_grnt, m1_grnt, owner, bus_busy, timeout_err}
  typedef struct {
    int         sel;
    logic       m0_;
    logic       m1_;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         tests  = 0;
  int         failed = 0;

  function automatic logic [4:0] get_out(input int sel);
    case (sel)
      0:       return {a_m0g, a_m1g, a_own, a_busy, a_terr};
      1:       return {b_m0g, b_m1g, b_own, b_busy, b_terr};
      default: return {c_m0g, c_m1g, c_own, c_busy, c_terr};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  task automatic add(input int sel, input logic m0_, input logic m1_, input logic [4:0] e);
    vec_t v;
    v.sel = sel;
    v.m0_ = m0_;
    v.m1_ = m1_;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    logic [4:0] e;
    for (int i = 0; i < vecs.size(); i++) begin
      m0_req_ = vecs[i].m0_;
      m1_req_ = vecs[i].m1_;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i), 32'(get_out(vecs[i].sel)), 32'(e));
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    m0_req_ = 1'b1;
    m1_req_ = 1'b1;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ok;

    // Reset state on all instances
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_a", 32'(get_out(0)), 32'b00000);
    check("rst_b", 32'(get_out(1)), 32'b00000);
    check("rst_c", 32'(get_out(2)), 32'b00000);

    // Single master hold, TIMEOUT=255
    do_reset();
    for (int i = 0; i < 5; i++) add(0, 1'b0, 1'b1, 5'b10010);
    add(0, 1'b1, 1'b1, 5'b00000);
    run_vecs("single_m0");

    // Simultaneous requests: m0 first, IDLE gap, m1, then m0 again
    do_reset();
    add(0, 1'b0, 1'b0, 5'b10010);
    add(0, 1'b0, 1'b0, 5'b10010);
    add(0, 1'b1, 1'b0, 5'b00000);
    add(0, 1'b1, 1'b0, 5'b01110);
    add(0, 1'b1, 1'b0, 5'b01110);
    add(0, 1'b1, 1'b1, 5'b00100);
    add(0, 1'b0, 1'b0, 5'b10010);
    add(0, 1'b1, 1'b1, 5'b00000);
    run_vecs("rr");

    // TIMEOUT=4, m0 alone held: 4 high, 1 idle with error pulse, 4 high
    do_reset();
    for (int i = 0; i < 4; i++) add(1, 1'b0, 1'b1, 5'b10010);
    add(1, 1'b0, 1'b1, 5'b00001);
    for (int i = 0; i < 4; i++) add(1, 1'b0, 1'b1, 5'b10010);
    add(1, 1'b0, 1'b1, 5'b00001);
    add(1, 1'b1, 1'b1, 5'b00000);
    run_vecs("wd_single");

    // TIMEOUT=4, both held: alternate; final release at the expiry compare is a normal release
    do_reset();
    for (int i = 0; i < 4; i++) add(1, 1'b0, 1'b0, 5'b10010);
    add(1, 1'b0, 1'b0, 5'b00001);
    for (int i = 0; i < 4; i++) add(1, 1'b0, 1'b0, 5'b01110);
    add(1, 1'b0, 1'b0, 5'b00101);
    for (int i = 0; i < 4; i++) add(1, 1'b0, 1'b0, 5'b10010);
    add(1, 1'b1, 1'b1, 5'b00000);
    run_vecs("wd_both");

    // TIMEOUT=0: a 300-cycle hold is never revoked
    do_reset();
    m0_req_ = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (c_m0g && !c_terr) ok++;
    end
    check("no_wd_hold", 32'(ok), 32'd300);
    m0_req_ = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while m1 owns the bus, then both request: m0 wins
    do_reset();
    add(0, 1'b1, 1'b0, 5'b01110);
    add(0, 1'b1, 1'b0, 5'b01110);
    run_vecs("pre_arst");
    #3;
    reset = 1'b1;
    #1;
    check("arst_a", 32'(get_out(0)), 32'b00000);
    check("arst_b", 32'(get_out(1)), 32'b00000);
    @(negedge clk);
    reset = 1'b0;
    add(0, 1'b0, 1'b0, 5'b10010);
    add(0, 1'b1, 1'b1, 5'b00000);
    run_vecs("post_arst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
